// File: rtl/vram_dma_pkg.sv
// ============================================================================
// Module      : vram_dma_pkg
// Description : Shared FSM state type, register map and bit positions of the
//               VRAM DMA engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vram_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_LATCH = 3'd2,
        ST_WR    = 3'd3,
        ST_FIN   = 3'd4
    } dma_state_t;

    localparam logic [2:0] REG_SRC_LO = 3'd0;
    localparam logic [2:0] REG_SRC_HI = 3'd1;
    localparam logic [2:0] REG_DST_LO = 3'd2;
    localparam logic [2:0] REG_DST_HI = 3'd3;
    localparam logic [2:0] REG_LEN_LO = 3'd4;
    localparam logic [2:0] REG_LEN_HI = 3'd5;
    localparam logic [2:0] REG_CTRL   = 3'd6;
    localparam logic [2:0] REG_STAT   = 3'd7;

    localparam int CTRL_START = 0;
    localparam int CTRL_MODE  = 1;
    localparam int CTRL_IRQEN = 2;
    localparam int CTRL_ABORT = 7;

    localparam int STAT_DONE = 0;
    localparam int STAT_BUSY = 1;

endpackage

`default_nettype wire

// File: rtl/vram_dma.sv
// ============================================================================
// Module      : vram_dma
// Description : VRAM copy/fill DMA engine sharing the VRAM CPU port with the
//               CPU bus (CPU always wins). Fill mode needs VRAM_DMA_FILL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_dma
    import vram_dma_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        io_addr,
    input  logic [7:0]        io_wrdata,
    input  logic              io_wren,
    output logic [7:0]        io_rddata,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wrdata,
    input  logic              cpu_wren,
    input  logic              cpu_rden,
    output logic [7:0]        cpu_rddata,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wrdata,
    output logic              vram_wren,
    input  logic [7:0]        vram_rddata,
    output logic              busy,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    dma_state_t        state, state_nxt;
    logic [ADDR_W-1:0] src, dst, len;
    logic [7:0]        rd_buf;
    logic [7:0]        wbyte;
    logic              irqen, done, mode;
    logic              grant, ctrl_wr, stat_wr, start, abort, start_fill, dma_wr;

    assign grant   = !(cpu_wren || cpu_rden);
    assign ctrl_wr = io_wren && (io_addr == REG_CTRL);
    assign stat_wr = io_wren && (io_addr == REG_STAT);
    assign abort   = ctrl_wr && io_wrdata[CTRL_ABORT];
    assign start   = ctrl_wr && io_wrdata[CTRL_START] && !abort && (state == ST_IDLE);
    assign dma_wr  = (state == ST_WR) && grant;
    assign busy    = (state != ST_IDLE);
    assign irq     = done && irqen;
    assign cpu_rddata = vram_rddata;

`ifdef VRAM_DMA_FILL_EN
    assign start_fill = io_wrdata[CTRL_MODE];
    assign wbyte      = mode ? src[7:0] : rd_buf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mode <= 1'b0;
        else if (ctrl_wr && !busy)
            mode <= io_wrdata[CTRL_MODE];
    end
`else
    assign start_fill = 1'b0;
    assign wbyte      = rd_buf;
    assign mode       = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state plus the shared-port mux; a CPU strobe always owns the port.
    always_comb begin
        state_nxt   = state;
        vram_addr   = cpu_addr;
        vram_wrdata = 8'h00;
        vram_wren   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0)      state_nxt = ST_FIN;
                    else if (start_fill) state_nxt = ST_WR;
                    else                state_nxt = ST_RD;
                end
            end
            ST_RD:    if (grant) state_nxt = ST_LATCH;
            ST_LATCH: state_nxt = ST_WR;
            ST_WR: begin
                if (grant) begin
                    if (len == ONE) state_nxt = ST_FIN;
                    else if (mode)  state_nxt = ST_WR;
                    else            state_nxt = ST_RD;
                end
            end
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (abort)
            state_nxt = ST_IDLE;

        if (!grant) begin
            vram_wrdata = cpu_wrdata;
            vram_wren   = cpu_wren;
        end else if (state == ST_RD) begin
            vram_addr   = src;
        end else if (state == ST_WR) begin
            vram_addr   = dst;
            vram_wrdata = wbyte;
            vram_wren   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src    <= '0;
            dst    <= '0;
            len    <= '0;
            rd_buf <= 8'h00;
            irqen  <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (io_wren && !busy) begin
                case (io_addr)
                    REG_SRC_LO: src[7:0]        <= io_wrdata;
                    REG_SRC_HI: src[ADDR_W-1:8] <= io_wrdata[ADDR_W-9:0];
                    REG_DST_LO: dst[7:0]        <= io_wrdata;
                    REG_DST_HI: dst[ADDR_W-1:8] <= io_wrdata[ADDR_W-9:0];
                    REG_LEN_LO: len[7:0]        <= io_wrdata;
                    REG_LEN_HI: len[ADDR_W-1:8] <= io_wrdata[ADDR_W-9:0];
                    default: ;
                endcase
            end
            if (ctrl_wr)
                irqen <= io_wrdata[CTRL_IRQEN];
            // The cycle before LATCH was always the DMA's own granted read.
            if (state == ST_LATCH)
                rd_buf <= vram_rddata;
            if (dma_wr) begin
                dst <= dst + ONE;
                len <= len - ONE;
                if (!mode)
                    src <= src + ONE;
            end
            if (state == ST_FIN && !abort)
                done <= 1'b1;
            else if (stat_wr && io_wrdata[STAT_DONE])
                done <= 1'b0;
        end
    end

    always_comb begin
        io_rddata = 8'h00;
        case (io_addr)
            REG_SRC_LO: io_rddata = src[7:0];
            REG_SRC_HI: io_rddata = 8'(src >> 8);
            REG_DST_LO: io_rddata = dst[7:0];
            REG_DST_HI: io_rddata = 8'(dst >> 8);
            REG_LEN_LO: io_rddata = len[7:0];
            REG_LEN_HI: io_rddata = 8'(len >> 8);
            REG_CTRL: begin
                io_rddata[CTRL_MODE]  = mode;
                io_rddata[CTRL_IRQEN] = irqen;
            end
            REG_STAT: begin
                io_rddata[STAT_DONE] = done;
                io_rddata[STAT_BUSY] = busy;
            end
            default: io_rddata = 8'h00;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_vram_dma.sv
// ============================================================================
// Module      : tb_vram_dma
// Description : Scoreboard bench for vram_dma with a behavioural 1-cycle VRAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_dma;

    typedef struct {
        logic [13:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  io_addr = '0;
    logic [7:0]  io_wrdata = '0;
    logic        io_wren = 1'b0;
    logic [7:0]  io_rddata;
    logic [13:0] cpu_addr = 14'h1234;
    logic [7:0]  cpu_wrdata = 8'h00;
    logic        cpu_wren = 1'b0;
    logic        cpu_rden = 1'b0;
    logic [7:0]  cpu_rddata;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wrdata;
    logic        vram_wren;
    logic [7:0]  vram_rddata = 8'h00;
    logic        busy;
    logic        irq;

    logic [7:0]  mem [0:16383];
    wr_t         exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    vram_dma #(.ADDR_W(14)) dut (
        .clk(clk), .reset(reset),
        .io_addr(io_addr), .io_wrdata(io_wrdata), .io_wren(io_wren), .io_rddata(io_rddata),
        .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata), .cpu_wren(cpu_wren), .cpu_rden(cpu_rden),
        .cpu_rddata(cpu_rddata),
        .vram_addr(vram_addr), .vram_wrdata(vram_wrdata), .vram_wren(vram_wren),
        .vram_rddata(vram_rddata),
        .busy(busy), .irq(irq)
    );

    always #50 clk = ~clk;

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 37) ^ (a >> 6));
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (vram_wren)
            mem[vram_addr] <= vram_wrdata;
        vram_rddata <= mem[vram_addr];
    end

    // Every write not owned by the CPU must be the next scoreboard entry.
    always @(negedge clk) begin
        if (cpu_wren) begin
            check("cpu_pass", {vram_wren, vram_addr, vram_wrdata}, {1'b1, cpu_addr, cpu_wrdata});
        end else if (vram_wren) begin
            if (exp_q.size() == 0) begin
                check("dma_wr_unexpected", {vram_addr, vram_wrdata}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("dma_wr", {vram_addr, vram_wrdata}, {e.a, e.d});
            end
        end
    end

    task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
        io_addr   = a;
        io_wrdata = d;
        io_wren   = 1'b1;
        @(posedge clk); #1;
        io_wren   = 1'b0;
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
        io_addr = a;
        #1;
        d = io_rddata;
    endtask

    task automatic setup(input logic [13:0] s, input logic [13:0] t, input logic [13:0] n);
        reg_wr(3'd0, s[7:0]);  reg_wr(3'd1, 8'(s >> 8));
        reg_wr(3'd2, t[7:0]);  reg_wr(3'd3, 8'(t >> 8));
        reg_wr(3'd4, n[7:0]);  reg_wr(3'd5, 8'(n >> 8));
    endtask

    task automatic push_copy(input int s, input int t, input int n);
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.a = 14'(t + i);
            e.d = pat((s + i) % 16384);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 500) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("busy_timeout", busy, 0);
    endtask

    initial begin
        logic [7:0] v;
        int cnt, ncpu;

        for (int i = 0; i < 16384; i++) mem[i] = pat(i);

        #10;
        check("rst_vram_addr", vram_addr, 14'h1234);
        check("rst_vram_wrdata", vram_wrdata, 0);
        check("rst_vram_wren", vram_wren, 0);
        check("rst_busy", busy, 0);
        check("rst_irq", irq, 0);
        for (int r = 0; r < 8; r++) begin
            reg_rd(3'(r), v);
            check($sformatf("rst_reg%0d", r), v, 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        // Plain copy, 4 bytes: 3 cycles/byte plus the FIN cycle.
        setup(14'h0100, 14'h0200, 14'd4);
        push_copy('h100, 'h200, 4);
        reg_wr(3'd6, 8'h01);
        check("cp_busy_start", busy, 1);
        run_busy(cnt);
        check("cp_busy_cycles", cnt, 13);
        reg_rd(3'd7, v); check("cp_stat", v, 8'h01);
        reg_rd(3'd0, v); check("cp_src_lo", v, 8'h04);
        reg_rd(3'd1, v); check("cp_src_hi", v, 8'h01);
        reg_rd(3'd2, v); check("cp_dst_lo", v, 8'h04);
        reg_rd(3'd3, v); check("cp_dst_hi", v, 8'h02);
        reg_rd(3'd4, v); check("cp_len_lo", v, 8'h00);
        reg_rd(3'd5, v); check("cp_len_hi", v, 8'h00);
        check("cp_irq_off", irq, 0);
        check("cp_sb_empty", exp_q.size(), 0);
        reg_wr(3'd7, 8'h01);

        // Fill (or copy when fill is not built) with DST wrapping past the top.
        setup(14'h00A5, 14'h3FFE, 14'd3);
`ifdef VRAM_DMA_FILL_EN
        for (int i = 0; i < 3; i++) begin
            wr_t e;
            e.a = 14'(14'h3FFE + i);
            e.d = 8'hA5;
            exp_q.push_back(e);
        end
        reg_wr(3'd6, 8'h03);
        run_busy(cnt);
        check("fill_busy_cycles", cnt, 4);
        reg_rd(3'd0, v); check("fill_src_lo", v, 8'hA5);
        reg_rd(3'd6, v); check("fill_ctrl", v, 8'h02);
`else
        push_copy('hA5, 'h3FFE, 3);
        reg_wr(3'd6, 8'h03);
        run_busy(cnt);
        check("nofill_busy_cycles", cnt, 10);
        reg_rd(3'd0, v); check("nofill_src_lo", v, 8'hA8);
        reg_rd(3'd6, v); check("nofill_ctrl", v, 8'h00);
`endif
        reg_rd(3'd2, v); check("wrap_dst_lo", v, 8'h01);
        reg_rd(3'd3, v); check("wrap_dst_hi", v, 8'h00);
        check("wrap_sb_empty", exp_q.size(), 0);
        reg_wr(3'd7, 8'h01);

        // CPU read sees data one cycle after the strobe.
        cpu_addr = 14'h0201;
        cpu_rden = 1'b1;
        @(posedge clk); #1;
        cpu_rden = 1'b0;
        check("cpu_rd", cpu_rddata, pat('h101));

        // Copy under CPU write traffic every other cycle.
        setup(14'h0400, 14'h0500, 14'd8);
        push_copy('h400, 'h500, 8);
        reg_wr(3'd6, 8'h01);
        cnt = 0;
        ncpu = 0;
        while (busy && cnt < 500) begin
            if (cnt % 2 == 0) begin
                cpu_addr   = 14'h0010;
                cpu_wrdata = 8'h55;
                cpu_wren   = 1'b1;
                ncpu++;
            end else begin
                cpu_wren   = 1'b0;
            end
            cnt++;
            @(posedge clk); #1;
        end
        cpu_wren = 1'b0;
        check("cont_time_lo", cnt >= 25, 1);
        check("cont_time_hi", cnt <= 25 + ncpu, 1);
        check("cont_cpu_data", mem[14'h0010], 8'h55);
        check("cont_sb_empty", exp_q.size(), 0);
        reg_wr(3'd7, 8'h01);

        // LEN=0: no write, DONE two cycles after START, irq with IRQEN.
        setup(14'h0000, 14'h0000, 14'd0);
        reg_wr(3'd6, 8'h05);
        reg_rd(3'd7, v); check("len0_stat_fin", v, 8'h02);
        check("len0_irq_early", irq, 0);
        @(posedge clk); #1;
        reg_rd(3'd7, v); check("len0_stat_done", v, 8'h01);
        check("len0_irq", irq, 1);
        reg_wr(3'd7, 8'h01);
        check("len0_irq_clr", irq, 0);

        // ABORT together with START: nothing starts.
        setup(14'h0000, 14'h0000, 14'd5);
        reg_wr(3'd6, 8'h81);
        check("abst_busy", busy, 0);
        reg_rd(3'd7, v); check("abst_stat", v, 8'h00);

        // ABORT after 2 of 6 bytes.
        setup(14'h0600, 14'h0700, 14'd6);
        push_copy('h600, 'h700, 2);
        reg_wr(3'd6, 8'h01);
        cnt = 0;
        reg_rd(3'd4, v);
        while (v != 8'd4 && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
            reg_rd(3'd4, v);
        end
        check("ab_len_reach", v, 8'd4);
        reg_wr(3'd6, 8'h80);
        check("ab_busy", busy, 0);
        reg_rd(3'd7, v); check("ab_stat", v, 8'h00);
        reg_rd(3'd4, v); check("ab_len_lo", v, 8'h04);
        reg_rd(3'd0, v); check("ab_src_lo", v, 8'h02);
        repeat (5) @(posedge clk);
        #1;
        check("ab_sb_empty", exp_q.size(), 0);

        // Reset in the WR state kills the write at once.
        setup(14'h0800, 14'h0900, 14'd3);
        reg_wr(3'd6, 8'h01);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstwr_pre_wren", vram_wren, 1);
        reset = 1'b1;
        #1;
        check("rstwr_wren", vram_wren, 0);
        check("rstwr_busy", busy, 0);
        for (int r = 0; r < 8; r++) begin
            reg_rd(3'(r), v);
            check($sformatf("rstwr_reg%0d", r), v, 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("final_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
